ahb_rr_arbiter: RTL and testbench
=================================

AHB_RR_ARBITER -- requirements
Module: ahb_rr_arbiter

Interface
REQ-001 SHALL provide parameter NUM_MASTERS, default 4, number of requesting masters (2..16).
REQ-002 SHALL provide parameter RR_MODE, default 1, where 1 = round-robin and 0 = fixed priority with lowest index highest.
REQ-003 SHALL provide parameter DEFAULT_MASTER, default 0, park master when no requests.
REQ-004 SHALL provide parameter MAX_HOLD, default 16, max hready-qualified cycles an unlocked owner keeps the bus while others request.
REQ-005 SHALL provide port clk  input  1  single clock, rising edge.
REQ-006 SHALL provide port rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL provide port hbusreq  input  NUM_MASTERS  per-master bus request.
REQ-008 SHALL provide port hlock  input  NUM_MASTERS  per-master locked-transfer request.
REQ-009 SHALL provide port hready  input  1  bus transfer-complete strobe.
REQ-010 SHALL provide port hgrant  output  NUM_MASTERS  registered one-hot grant.
REQ-011 SHALL provide port hmaster  output  clog2(NUM_MASTERS)  registered index of address-phase owner.
REQ-012 SHALL provide port hmastlock  output  1  registered lock flag of address-phase owner.

Function
REQ-013 SHALL implement states IDLE (parked, no request), GRANT (unlocked owner), LOCKED (locked owner).
REQ-014 SHALL update hgrant, state, hold counter and RR pointer only on edges where hready=1; with hready=0 all hold their values.
REQ-015 SHALL keep hgrant exactly one-hot at all times after reset.
REQ-016 SHALL rearbitrate (hready=1) when: state IDLE; or owner drops hbusreq and hlock; or state GRANT, hold counter = MAX_HOLD-1 and another master requests.
REQ-017 SHALL pick winner in RR_MODE=1 as first requester scanning from (last owner+1) mod NUM_MASTERS upward with wrap; in RR_MODE=0 as lowest requesting index.
REQ-018 SHALL, when no master requests at a rearbitration point, grant DEFAULT_MASTER and enter IDLE.
REQ-019 SHALL enter LOCKED when the winner has hlock=1, else GRANT.
REQ-020 SHALL in LOCKED ignore the hold counter and other requests; exit only when owner has hbusreq=0 and hlock=0.
REQ-021 SHALL, in GRANT, increment hold counter on each hready=1 cycle; reset to 0 on every grant change; saturate at MAX_HOLD-1.
REQ-022 SHALL, when sole requester is the owner at MAX_HOLD-1, keep the grant and clear the counter.
REQ-023 SHALL update RR pointer to the winner index only when a requesting master wins (not on park).
REQ-024 SHALL load hmaster with index of hgrant and hmastlock with state==LOCKED on each hready=1 edge, lagging hgrant by one hready cycle.
REQ-025 SHALL give grant decision latency of one cycle: request sampled at edge t with hready=1 -> hgrant valid after edge t.
REQ-026 SHALL treat hbusreq/hlock for indices with simultaneous assertion fairly per REQ-017; an hlock without hbusreq is ignored at arbitration.

Reset
REQ-027 SHALL on rstn=0 at clk edge set hgrant = one-hot DEFAULT_MASTER, hmaster = DEFAULT_MASTER, hmastlock = 0, state IDLE, counter 0, RR pointer = DEFAULT_MASTER.
REQ-028 SHALL let reset override hready and any in-progress lock; first arbitration occurs on first edge after rstn=1 with hready=1.

Verification
REQ-029 SHALL cover: reset, no requests -> hgrant=4'b0001, hmaster=0, hmastlock=0.
REQ-030 SHALL cover: RR_MODE=1, hbusreq=4'b1111 constant, MAX_HOLD=2, hready=1 -> grants cycle 1,2,3,0 each held 2 cycles.
REQ-031 SHALL cover: RR_MODE=0, hbusreq=4'b1010 -> hgrant=4'b0010 persists past MAX_HOLD; hbusreq[1] drop -> 4'b1000 next cycle.
REQ-032 SHALL cover: master 2 granted with hlock=1, hbusreq=4'b1111 for 40 cycles -> hgrant=4'b0100, hmastlock=1 throughout; deassert -> next master 3.
REQ-033 SHALL cover: hready=0 for 5 cycles while owner drops request -> hgrant, hmaster unchanged until hready=1, then switch.
REQ-034 SHALL cover: rstn=0 mid-LOCKED -> outputs return to reset values next edge, hmastlock=0.

Source files
------------

// File: rtl/ahb_rr_arbiter_if.sv
// AHB arbitration bus bundle: per-master request/lock inputs, ready strobe,
// and the registered grant / address-phase owner outputs.
interface ahb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int IW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic                   hready;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [IW-1:0]          hmaster;
  logic                   hmastlock;

  modport master (
    output hbusreq, hlock, hready,
    input  hgrant, hmaster, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, hready,
    output hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// AHB bus arbiter: round-robin or fixed-priority grant with locked transfers,
// bounded hold time for unlocked owners and parking on a default master.
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int RR_MODE        = 1,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16
) (
  input logic             clk,
  input logic             rstn,
  ahb_rr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [NUM_MASTERS-1:0] DEFAULT_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [IW-1:0]          DEFAULT_IDX = IW'(DEFAULT_MASTER);
  localparam logic [CW-1:0]          HOLD_LAST   = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    LOCKED
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          hold_q, hold_d;
  logic [IW-1:0]          hmaster_q;
  logic                   hmastlock_q;

  logic [NUM_MASTERS-1:0] above_ptr, req_above, win_oh;
  logic [IW-1:0]          win_idx, owner_idx;
  logic                   any_req, others_req, owner_drop, win_lock, rearb;

  function automatic logic [NUM_MASTERS-1:0] lowest_one(input logic [NUM_MASTERS-1:0] v);
    return v & (~v + NUM_MASTERS'(1));
  endfunction

  // Winner selection: round-robin prefers requesters above the last winner,
  // wrapping to the lowest requester; fixed priority always takes the lowest.
  always_comb begin
    above_ptr = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      above_ptr[i] = (i > int'(ptr_q));
    end
    req_above = bus.hbusreq & above_ptr;
    if (RR_MODE != 0 && req_above != '0) begin
      win_oh = lowest_one(req_above);
    end else begin
      win_oh = lowest_one(bus.hbusreq);
    end

    win_idx   = '0;
    owner_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win_oh[i])  win_idx   = IW'(i);
      if (grant_q[i]) owner_idx = IW'(i);
    end

    any_req    = |bus.hbusreq;
    others_req = |(bus.hbusreq & ~grant_q);
    owner_drop = ~|(bus.hbusreq & grant_q) && ~|(bus.hlock & grant_q);
    win_lock   = |(bus.hlock & win_oh);
  end

  // NOTE: every output of this block gets a default first so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE:    rearb = 1'b1;
      GRANT:   rearb = owner_drop || (hold_q == HOLD_LAST && others_req);
      LOCKED:  rearb = owner_drop;
      default: rearb = 1'b1;
    endcase

    if (rearb) begin
      hold_d = '0;
      if (any_req) begin
        grant_d = win_oh;
        ptr_d   = win_idx;
        state_d = win_lock ? LOCKED : GRANT;
      end else begin
        grant_d = DEFAULT_OH;
        state_d = IDLE;
      end
    end else if (state_q == GRANT) begin
      // Reaching the hold limit with nobody else waiting restarts the window.
      hold_d = (hold_q == HOLD_LAST) ? '0 : hold_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      grant_q     <= DEFAULT_OH;
      ptr_q       <= DEFAULT_IDX;
      hold_q      <= '0;
      hmaster_q   <= DEFAULT_IDX;
      hmastlock_q <= 1'b0;
    end else if (bus.hready) begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      hmaster_q   <= owner_idx;
      hmastlock_q <= (state_q == LOCKED);
    end
  end

  assign bus.hgrant    = grant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = hmastlock_q;
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Self-checking bench: a round-robin (MAX_HOLD=2) and a fixed-priority
// (MAX_HOLD=4) arbiter share stimulus and are compared against a model.
module tb_ahb_rr_arbiter;
  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic       hready;

  int n_checks = 0;
  int n_errors = 0;

  ahb_rr_arbiter_if #(.NUM_MASTERS(4)) bus_rr ();
  ahb_rr_arbiter_if #(.NUM_MASTERS(4)) bus_fp ();

  assign bus_rr.hbusreq = hbusreq;
  assign bus_rr.hlock   = hlock;
  assign bus_rr.hready  = hready;
  assign bus_fp.hbusreq = hbusreq;
  assign bus_fp.hlock   = hlock;
  assign bus_fp.hready  = hready;

  ahb_rr_arbiter #(.NUM_MASTERS(4), .RR_MODE(1), .DEFAULT_MASTER(0), .MAX_HOLD(2)) dut_rr (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_rr)
  );

  ahb_rr_arbiter #(.NUM_MASTERS(4), .RR_MODE(0), .DEFAULT_MASTER(0), .MAX_HOLD(4)) dut_fp (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_fp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [3:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  // Model state per arbiter (0 = round-robin, 1 = fixed priority).
  int owner[2]  = '{0, 0};
  int hold[2]   = '{0, 0};
  int last[2]   = '{0, 0};
  int exp_hm[2] = '{0, 0};
  bit idle[2]   = '{1, 1};
  bit locked[2] = '{0, 0};
  bit exp_hl[2] = '{0, 0};

  task automatic model_step(input int d);
    int  max_hold;
    bit  others, drop, rearb;
    int  win;
    max_hold = (d == 0) ? 2 : 4;
    if (!rstn) begin
      owner[d] = 0; hold[d] = 0; last[d] = 0; exp_hm[d] = 0;
      idle[d] = 1'b1; locked[d] = 1'b0; exp_hl[d] = 1'b0;
      return;
    end
    if (!hready) return;

    exp_hm[d] = owner[d];
    exp_hl[d] = locked[d];
    others = 1'b0;
    for (int i = 0; i < 4; i++) if (i != owner[d] && bit_of(hbusreq, i)) others = 1'b1;
    drop = !bit_of(hbusreq, owner[d]) && !bit_of(hlock, owner[d]);

    if (idle[d])        rearb = 1'b1;
    else if (locked[d]) rearb = drop;
    else                rearb = drop || (hold[d] == max_hold - 1 && others);

    if (rearb) begin
      hold[d] = 0;
      win = -1;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (d == 0) ? (last[d] + 1 + k) % 4 : k;
        if (win < 0 && bit_of(hbusreq, i)) win = i;
      end
      if (win < 0) begin
        owner[d] = 0; idle[d] = 1'b1; locked[d] = 1'b0;
      end else begin
        owner[d] = win; last[d] = win; idle[d] = 1'b0; locked[d] = bit_of(hlock, win);
      end
    end else if (!locked[d]) begin
      hold[d] = (hold[d] == max_hold - 1) ? 0 : hold[d] + 1;
    end
  endtask

  // Cycle-by-cycle comparison of both arbiters against the model.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) model_step(d);
    check("rr hgrant",    32'(bus_rr.hgrant),    32'(4'b0001 << owner[0]));
    check("rr hmaster",   32'(bus_rr.hmaster),   32'(exp_hm[0]));
    check("rr hmastlock", 32'(bus_rr.hmastlock), 32'(exp_hl[0]));
    check("fp hgrant",    32'(bus_fp.hgrant),    32'(4'b0001 << owner[1]));
    check("fp hmaster",   32'(bus_fp.hmaster),   32'(exp_hm[1]));
    check("fp hmastlock", 32'(bus_fp.hmastlock), 32'(exp_hl[1]));
  end

  // Inputs change on the falling edge; returns at the next falling edge.
  task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic rdy, input logic rs);
    hbusreq = r;
    hlock   = l;
    hready  = rdy;
    rstn    = rs;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] rr_seq [8];
    logic [3:0] r, l;
    rr_seq = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};

    rstn = 1'b0; hbusreq = '0; hlock = '0; hready = 1'b1;
    @(negedge clk);

    // Reset with no requests parks on master 0.
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
    check("reset rr hgrant",    32'(bus_rr.hgrant),    32'h1);
    check("reset rr hmaster",   32'(bus_rr.hmaster),   32'h0);
    check("reset rr hmastlock", 32'(bus_rr.hmastlock), 32'h0);
    check("reset fp hgrant",    32'(bus_fp.hgrant),    32'h1);

    // All request, hold limit 2: round-robin visits 1,2,3,0 for two cycles each.
    for (int c = 0; c < 8; c++) begin
      cycle(4'b1111, 4'b0000, 1'b1, 1'b1);
      check("rr rotation", 32'(bus_rr.hgrant), 32'(rr_seq[c]));
      check("fp stays 0",  32'(bus_fp.hgrant), 32'h1);
    end

    // Fixed priority keeps master 1 past the hold limit, then hands to 3.
    for (int c = 0; c < 10; c++) begin
      cycle(4'b1010, 4'b0000, 1'b1, 1'b1);
      check("fp keeps 1", 32'(bus_fp.hgrant), 32'h2);
    end
    cycle(4'b1000, 4'b0000, 1'b1, 1'b1);
    check("fp drop to 3", 32'(bus_fp.hgrant), 32'h8);

    // Master 2 locks the bus against all others for 40 cycles.
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0100, 4'b0100, 1'b1, 1'b1);
    check("lock grant rr", 32'(bus_rr.hgrant), 32'h4);
    check("lock grant fp", 32'(bus_fp.hgrant), 32'h4);
    for (int c = 0; c < 40; c++) begin
      cycle(4'b1111, 4'b0100, 1'b1, 1'b1);
      check("locked rr hgrant",    32'(bus_rr.hgrant),    32'h4);
      check("locked rr hmastlock", 32'(bus_rr.hmastlock), 32'h1);
      check("locked fp hgrant",    32'(bus_fp.hgrant),    32'h4);
    end
    cycle(4'b1011, 4'b0000, 1'b1, 1'b1);
    check("unlock rr next 3", 32'(bus_rr.hgrant), 32'h8);
    check("unlock fp next 0", 32'(bus_fp.hgrant), 32'h1);

    // Stalled bus: owner 3 drops its request while hready is low.
    cycle(4'b1011, 4'b0000, 1'b1, 1'b1);
    check("rr hmaster 3", 32'(bus_rr.hmaster), 32'h3);
    for (int c = 0; c < 5; c++) begin
      cycle(4'b0111, 4'b0000, 1'b0, 1'b1);
      check("stall rr hgrant",  32'(bus_rr.hgrant),  32'h8);
      check("stall rr hmaster", 32'(bus_rr.hmaster), 32'h3);
    end
    cycle(4'b0111, 4'b0000, 1'b1, 1'b1);
    check("stall release rr", 32'(bus_rr.hgrant), 32'h1);

    // Reset while master 1 holds a lock, with hready low.
    cycle(4'b0010, 4'b0010, 1'b1, 1'b1);
    cycle(4'b0010, 4'b0010, 1'b1, 1'b1);
    check("pre-reset rr hmastlock", 32'(bus_rr.hmastlock), 32'h1);
    cycle(4'b0010, 4'b0010, 1'b0, 1'b0);
    check("mid-lock reset hgrant",    32'(bus_rr.hgrant),    32'h1);
    check("mid-lock reset hmaster",   32'(bus_rr.hmaster),   32'h0);
    check("mid-lock reset hmastlock", 32'(bus_rr.hmastlock), 32'h0);

    // Randomized traffic with held request patterns, stalls and rare resets.
    r = 4'($urandom);
    l = 4'($urandom & $urandom);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      if ($urandom_range(7) == 0) l = 4'($urandom & $urandom & $urandom);
      cycle(r, l, ($urandom_range(4) != 0), ($urandom_range(149) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
